// File: rtl/calc_sched_pkg.sv
// Shared types for the calc port scheduler: commands, response codes,
// per-port state encoding and the captured request record.
package calc_sched_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 32;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_PEND = 2'd2,
    ST_BUSY = 2'd3
  } port_state_t;

  // Command as received, so unsupported codes survive until they are rejected
  typedef struct packed {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } calc_req_t;

  // True for the commands the ALU understands
  function automatic logic cmd_is_valid(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR: cmd_is_valid = 1'b1;
      default:                            cmd_is_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/calc_port_ctrl.sv
// One requester port: captures a two-cycle command (cmd+op1, then op2),
// waits for arbitration, then waits for its ALU completion.
module calc_port_ctrl
  import calc_sched_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  cmd_i,
  input  logic [31:0] data_i,
  input  logic        grant_i,
  input  logic        done_i,
  output logic        pend_o,
  output logic        busy_o,
  output logic        invalid_o,
  output calc_req_t   req_o
);

  port_state_t state_q;
  calc_req_t   req_q;

  // Port FSM and operand capture; commands arriving outside IDLE are ignored
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_i != CMD_NOP) begin
            req_q.cmd <= cmd_i;
            req_q.op1 <= data_i;
            state_q   <= ST_OP2;
          end
        end
        ST_OP2: begin
          req_q.op2 <= data_i;
          state_q   <= cmd_is_valid(req_q.cmd) ? ST_PEND : ST_IDLE;
        end
        ST_PEND: begin
          if (grant_i) state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          if (done_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pend_o    = (state_q == ST_PEND);
  assign busy_o    = (state_q == ST_BUSY);
  // Unsupported command leaves OP2 this cycle; the top answers it next cycle
  assign invalid_o = (state_q == ST_OP2) && !cmd_is_valid(req_q.cmd);
  assign req_o     = req_q;

endmodule

// File: rtl/calc_port_scheduler.sv
// Four requester ports sharing one ALU: round-robin arbitration into a
// single issue register, tag-based response routing back to the ports.
module calc_port_scheduler
  import calc_sched_pkg::*;
#(
  parameter int NUM_PORTS = calc_sched_pkg::NUM_PORTS
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [31:0] req2_data_in,
  input  logic [31:0] req3_data_in,
  input  logic [31:0] req4_data_in,
  output logic [1:0]  out_resp1,
  output logic [1:0]  out_resp2,
  output logic [1:0]  out_resp3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data1,
  output logic [31:0] out_data2,
  output logic [31:0] out_data3,
  output logic [31:0] out_data4,
  output logic        alu_valid,
  output logic [3:0]  alu_cmd,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [1:0]  alu_tag,
  input  logic        alu_ready,
  input  logic        alu_rsp_valid,
  input  logic [1:0]  alu_rsp,
  input  logic [31:0] alu_rsp_data,
  input  logic [1:0]  alu_rsp_tag
);

  logic [3:0]           cmd_s     [NUM_PORTS];
  logic [31:0]          data_s    [NUM_PORTS];
  calc_req_t            req_s     [NUM_PORTS];
  logic [NUM_PORTS-1:0] pend_s;
  logic [NUM_PORTS-1:0] busy_s;
  logic [NUM_PORTS-1:0] invalid_s;
  logic [NUM_PORTS-1:0] done_s;
  logic [NUM_PORTS-1:0] grant_s;
  logic                 grant_any_s;
  logic [1:0]           grant_idx_s;
  logic [1:0]           scan_idx_s;
  logic                 can_load_s;

  logic [1:0]  ptr_q;
  logic        issue_valid_q;
  calc_req_t   issue_req_q;
  logic [1:0]  issue_tag_q;
  logic [1:0]  resp_q  [NUM_PORTS];
  logic [31:0] rdata_q [NUM_PORTS];

  assign cmd_s[0]  = req1_cmd_in;
  assign cmd_s[1]  = req2_cmd_in;
  assign cmd_s[2]  = req3_cmd_in;
  assign cmd_s[3]  = req4_cmd_in;
  assign data_s[0] = req1_data_in;
  assign data_s[1] = req2_data_in;
  assign data_s[2] = req3_data_in;
  assign data_s[3] = req4_data_in;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    // A completion only counts for a port actually waiting on the ALU
    assign done_s[p] = alu_rsp_valid && (alu_rsp_tag == 2'(p)) && busy_s[p];

    calc_port_ctrl u_ctrl (
      .clk_i     (c_clk),
      .rst_ni    (reset),
      .cmd_i     (cmd_s[p]),
      .data_i    (data_s[p]),
      .grant_i   (grant_s[p]),
      .done_i    (done_s[p]),
      .pend_o    (pend_s[p]),
      .busy_o    (busy_s[p]),
      .invalid_o (invalid_s[p]),
      .req_o     (req_s[p])
    );
  end

  // Issue register can take a new request when empty or being drained now
  assign can_load_s = !issue_valid_q || alu_ready;

  // Round-robin scan starting at the pointer; no grant if issue is blocked
  always_comb begin
    grant_s     = '0;
    grant_any_s = 1'b0;
    grant_idx_s = 2'd0;
    scan_idx_s  = 2'd0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx_s = ptr_q + 2'(k);
      if (can_load_s && !grant_any_s && pend_s[scan_idx_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = scan_idx_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (grant_any_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Issue register and arbitration pointer; contents held while stalled
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      issue_valid_q <= 1'b0;
      issue_req_q   <= '0;
      issue_tag_q   <= 2'd0;
      ptr_q         <= 2'd0;
    end else if (grant_any_s) begin
      issue_valid_q <= 1'b1;
      issue_req_q   <= req_s[grant_idx_s];
      issue_tag_q   <= grant_idx_s;
      ptr_q         <= grant_idx_s + 2'd1;
    end else if (alu_ready) begin
      issue_valid_q <= 1'b0;
    end
  end

  // One-cycle responses: invalid-command error or routed ALU completion
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!reset) begin
        resp_q[p]  <= RESP_NONE;
        rdata_q[p] <= 32'd0;
      end else if (invalid_s[p]) begin
        resp_q[p]  <= RESP_ERR;
        rdata_q[p] <= 32'd0;
      end else if (done_s[p]) begin
        resp_q[p]  <= alu_rsp;
        rdata_q[p] <= alu_rsp_data;
      end else begin
        resp_q[p]  <= RESP_NONE;
        rdata_q[p] <= 32'd0;
      end
    end
  end

  assign alu_valid = issue_valid_q;
  assign alu_cmd   = issue_req_q.cmd;
  assign alu_op1   = issue_req_q.op1;
  assign alu_op2   = issue_req_q.op2;
  assign alu_tag   = issue_tag_q;

  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data1 = rdata_q[0];
  assign out_data2 = rdata_q[1];
  assign out_data3 = rdata_q[2];
  assign out_data4 = rdata_q[3];

endmodule

// File: tb/tb_calc_port_scheduler.sv
// Bench for calc_port_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_calc_port_scheduler;

  logic             c_clk = 1'b0;
  logic             reset = 1'b0;
  logic [3:0][3:0]  cmd_v = '0;
  logic [3:0][31:0] din_v = '0;
  logic [3:0][1:0]  resp_v;
  logic [3:0][31:0] odata_v;
  logic             alu_valid;
  logic [3:0]       alu_cmd;
  logic [31:0]      alu_op1, alu_op2;
  logic [1:0]       alu_tag;
  logic             alu_ready = 1'b1;
  logic             alu_rsp_valid = 1'b0;
  logic [1:0]       alu_rsp = 2'd0;
  logic [31:0]      alu_rsp_data = 32'd0;
  logic [1:0]       alu_rsp_tag = 2'd0;

  calc_port_scheduler #(.NUM_PORTS(4)) dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd_v[0]), .req2_cmd_in(cmd_v[1]), .req3_cmd_in(cmd_v[2]), .req4_cmd_in(cmd_v[3]),
    .req1_data_in(din_v[0]), .req2_data_in(din_v[1]), .req3_data_in(din_v[2]), .req4_data_in(din_v[3]),
    .out_resp1(resp_v[0]), .out_resp2(resp_v[1]), .out_resp3(resp_v[2]), .out_resp4(resp_v[3]),
    .out_data1(odata_v[0]), .out_data2(odata_v[1]), .out_data3(odata_v[2]), .out_data4(odata_v[3]),
    .alu_valid(alu_valid), .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_tag(alu_tag),
    .alu_ready(alu_ready), .alu_rsp_valid(alu_rsp_valid), .alu_rsp(alu_rsp),
    .alu_rsp_data(alu_rsp_data), .alu_rsp_tag(alu_rsp_tag)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    logic [1:0]  tag;
    logic [1:0]  rsp;
    logic [31:0] data;
    int          due;
  } job_t;

  // Reference model: each port holds at most one transaction stamped with
  // the cycle its command arrived; the ALU is a queue of timed jobs.
  bit          m_have [4];
  int          m_t    [4];
  logic [3:0]  m_cmd  [4];
  logic [31:0] m_op1  [4];
  logic [31:0] m_op2  [4];
  bit          m_iss  [4];
  int          m_iss_c[4];
  int          m_ptr;
  bit          e_av;
  logic [3:0]  e_ac;
  logic [31:0] e_a1, e_a2;
  logic [1:0]  e_at;
  logic [1:0]  e_resp [4];
  logic [31:0] e_data [4];
  job_t        jobs[$];

  int cyc, n_vec, n_bad, dmin, dmax;
  int cnt_resp [4];
  logic [31:0] last_data [4];
  bit force_rsp;

  function automatic bit valid_cmd(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  // The ALU the scheduler talks to: arithmetic with overflow/underflow flag
  function automatic void alu_eval(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   output logic [1:0] r, output logic [31:0] d);
    logic [32:0] w;
    case (c)
      4'd1: begin w = {1'b0, a} + {1'b0, b}; d = w[31:0]; r = w[32] ? 2'd2 : 2'd1; end
      4'd2: begin d = a - b; r = (b > a) ? 2'd2 : 2'd1; end
      4'd5: begin d = a << b[4:0]; r = 2'd1; end
      4'd6: begin d = a >> b[4:0]; r = 2'd1; end
      default: begin d = 32'd0; r = 2'd2; end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Predict the registered outputs the coming edge produces
  task automatic model_step();
    bit          busy [4];
    bit          free [4];
    logic [1:0]  nr [4];
    logic [31:0] nd [4];
    logic [1:0]  jr;
    logic [31:0] jd;
    int g, q;
    if (e_av && alu_ready) begin
      alu_eval(e_ac, e_a1, e_a2, jr, jd);
      jobs.push_back('{tag: e_at, rsp: jr, data: jd, due: cyc + int'($urandom_range(dmin, dmax))});
    end
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        m_have[p] = 1'b0; m_iss[p] = 1'b0; e_resp[p] = 2'd0; e_data[p] = 32'd0;
      end
      m_ptr = 0; e_av = 1'b0; e_ac = 4'd0; e_a1 = 32'd0; e_a2 = 32'd0; e_at = 2'd0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        busy[p] = m_have[p] && m_iss[p] && (m_iss_c[p] < cyc);
        free[p] = !m_have[p];
        nr[p] = 2'd0; nd[p] = 32'd0;
        if (m_have[p] && cyc == m_t[p] + 1 && !valid_cmd(m_cmd[p])) nr[p] = 2'd2;
        if (alu_rsp_valid && int'(alu_rsp_tag) == p && busy[p]) begin
          nr[p] = alu_rsp; nd[p] = alu_rsp_data;
        end
      end
      g = -1;
      if (!e_av || alu_ready) begin
        for (int k = 0; k < 4; k++) begin
          q = (m_ptr + k) % 4;
          if (g < 0 && m_have[q] && !m_iss[q] && valid_cmd(m_cmd[q]) && cyc >= m_t[q] + 2) g = q;
        end
      end
      if (g >= 0) begin
        e_av = 1'b1; e_ac = m_cmd[g]; e_a1 = m_op1[g]; e_a2 = m_op2[g]; e_at = 2'(g);
        m_iss[g] = 1'b1; m_iss_c[g] = cyc; m_ptr = (g + 1) % 4;
      end else if (alu_ready) begin
        e_av = 1'b0;
      end
      for (int p = 0; p < 4; p++) begin
        if (m_have[p] && cyc == m_t[p] + 1) begin
          m_op2[p] = din_v[p];
          if (!valid_cmd(m_cmd[p])) m_have[p] = 1'b0;
        end
        if (alu_rsp_valid && int'(alu_rsp_tag) == p && busy[p]) m_have[p] = 1'b0;
        if (free[p] && cmd_v[p] != 4'd0) begin
          m_have[p] = 1'b1; m_t[p] = cyc; m_cmd[p] = cmd_v[p]; m_op1[p] = din_v[p]; m_iss[p] = 1'b0;
        end
        e_resp[p] = nr[p]; e_data[p] = nd[p];
      end
    end
  endtask

  task automatic check_all();
    chk("alu_valid", 32'(alu_valid), 32'(e_av));
    if (e_av) begin
      chk("alu_cmd", 32'(alu_cmd), 32'(e_ac));
      chk("alu_op1", alu_op1, e_a1);
      chk("alu_op2", alu_op2, e_a2);
      chk("alu_tag", 32'(alu_tag), 32'(e_at));
    end
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("out_resp%0d", p + 1), 32'(resp_v[p]), 32'(e_resp[p]));
      chk($sformatf("out_data%0d", p + 1), odata_v[p], e_data[p]);
      if (resp_v[p] != 2'd0) begin
        cnt_resp[p]++; last_data[p] = odata_v[p];
      end
    end
  endtask

  // One clock: drive the ALU response input, predict, clock, compare
  task automatic tick();
    int pick;
    if (force_rsp) begin
      force_rsp = 1'b0;
    end else begin
      alu_rsp_valid = 1'b0; alu_rsp = 2'd0; alu_rsp_data = 32'd0; alu_rsp_tag = 2'd0;
      pick = -1;
      foreach (jobs[i]) if (pick < 0 && jobs[i].due <= cyc) pick = i;
      if (pick >= 0) begin
        alu_rsp_valid = 1'b1; alu_rsp = jobs[pick].rsp;
        alu_rsp_data = jobs[pick].data; alu_rsp_tag = jobs[pick].tag;
        jobs.delete(pick);
      end
    end
    model_step();
    @(posedge c_clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic issue_cmd(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    cmd_v[p] = c; din_v[p] = a;
    tick();
    cmd_v[p] = 4'd0; din_v[p] = b;
    tick();
  endtask

  task automatic clr_cnt();
    for (int p = 0; p < 4; p++) begin cnt_resp[p] = 0; last_data[p] = 32'd0; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [3:0] rnd_cmds [7] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd7, 4'd15};

  initial begin
    cyc = 0; n_vec = 0; n_bad = 0; dmin = 1; dmax = 1; force_rsp = 1'b0; m_ptr = 0; e_av = 1'b0;
    for (int p = 0; p < 4; p++) begin m_have[p] = 1'b0; m_iss[p] = 1'b0; end
    clr_cnt();

    // Reset state
    reset = 1'b0;
    idle(2);
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_alu_op1", alu_op1, 32'd0);
    chk("rst_alu_op2", alu_op2, 32'd0);
    chk("rst_alu_cmd_tag", {26'd0, alu_cmd, alu_tag}, 32'd0);
    chk("rst_out_resp", 32'(resp_v), 32'd0);
    reset = 1'b1;

    // Port1 add 0x10+0x20, accepted in the first cycle out of reset
    issue_cmd(0, 4'd1, 32'h10, 32'h20);
    tick();
    chk("add_issue_valid", 32'(alu_valid), 32'd1);
    chk("add_issue_tag", 32'(alu_tag), 32'd0);
    idle(2);
    chk("add_resp", 32'(resp_v[0]), 32'd1);
    chk("add_data", odata_v[0], 32'h30);
    tick();
    chk("add_resp_one_cycle", 32'(resp_v[0]), 32'd0);

    // All four ports at once: tags issue 0..3 on consecutive cycles
    reset = 1'b0; tick(); reset = 1'b1;
    clr_cnt();
    for (int p = 0; p < 4; p++) begin cmd_v[p] = 4'd1; din_v[p] = 32'h100 * (p + 1); end
    tick();
    for (int p = 0; p < 4; p++) begin cmd_v[p] = 4'd0; din_v[p] = 32'(p + 7); end
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("rr_valid", 32'(alu_valid), 32'd1);
      chk("rr_tag", 32'(alu_tag), 32'(k));
      tick();
    end
    idle(4);
    for (int p = 0; p < 4; p++) chk("rr_one_resp", 32'(cnt_resp[p]), 32'd1);

    // Port3 unsupported command 7: error at T+2, no ALU use
    clr_cnt();
    issue_cmd(2, 4'd7, 32'd5, 32'd6);
    chk("inv_resp", 32'(resp_v[2]), 32'd2);
    chk("inv_data", odata_v[2], 32'd0);
    chk("inv_no_alu", 32'(alu_valid), 32'd0);
    idle(3);
    chk("inv_once", 32'(cnt_resp[2]), 32'd1);

    // Port2 sub stalled by alu_ready low for five cycles
    clr_cnt();
    alu_ready = 1'b0;
    issue_cmd(1, 4'd2, 32'd50, 32'd8);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(alu_valid), 32'd1);
      chk("stall_op1", alu_op1, 32'd50);
      tick();
    end
    alu_ready = 1'b1;
    chk("stall_sixth", 32'(alu_valid), 32'd1);
    idle(4);
    chk("stall_resp_cnt", 32'(cnt_resp[1]), 32'd1);
    chk("stall_resp_data", last_data[1], 32'd42);

    // Port4 sub in flight, reset pulse before its completion returns
    clr_cnt();
    dmin = 4; dmax = 4;
    issue_cmd(3, 4'd2, 32'd100, 32'd1);
    idle(4);
    reset = 1'b0; tick(); reset = 1'b1;
    tick();
    chk("late_rsp_dropped", 32'(resp_v[3]), 32'd0);
    idle(3);
    chk("late_rsp_cnt", 32'(cnt_resp[3]), 32'd0);

    // Port1 command while BUSY is ignored
    clr_cnt();
    dmin = 3; dmax = 3;
    issue_cmd(0, 4'd1, 32'd3, 32'd4);
    idle(2);
    cmd_v[0] = 4'd5; din_v[0] = 32'd9;
    tick();
    cmd_v[0] = 4'd0; din_v[0] = 32'd1;
    idle(8);
    chk("busy_ignore_cnt", 32'(cnt_resp[0]), 32'd1);
    chk("busy_ignore_data", last_data[0], 32'd7);

    // Completion for a port that is not BUSY is discarded
    force_rsp = 1'b1; alu_rsp_valid = 1'b1; alu_rsp_tag = 2'd2; alu_rsp = 2'd1; alu_rsp_data = 32'hdead;
    tick();
    chk("stray_rsp", 32'(resp_v[2]), 32'd0);

    // Random traffic with out-of-order completions, stalls and resets
    dmin = 1; dmax = 5;
    for (int i = 0; i < 600; i++) begin
      alu_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 199) != 0);
      for (int p = 0; p < 4; p++) begin
        int r;
        r = int'($urandom_range(0, 15));
        cmd_v[p] = (r < 9) ? 4'd0 : rnd_cmds[r - 9];
        din_v[p] = $urandom;
      end
      tick();
    end
    reset = 1'b1; alu_ready = 1'b1; cmd_v = '0;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
